// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and default multi-cycle latency for the hazard unit.
package hazard_pkg;
    typedef enum logic {RUN, MC_BUSY} state_t;
    localparam int MC_LAT_DEF = 4;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose nonzero destination feeds a source of the ID instruction.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_memread,
    output logic       lu
);
    assign lu = idex_memread && (idex_rd != 5'd0) && (idex_rd == id_rs1 || idex_rd == id_rs2);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, taken branches and multi-cycle EX ops,
// with a saturating count of PC-stall cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LAT      = MC_LAT_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             idex_rd,
    input  logic                   idex_memread,
    input  logic                   ex_branch_taken,
    input  logic                   ex_mc_start,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   idex_write,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic                   exmem_bubble,
    output logic                   mc_done,
    output logic [STALL_CNT_W-1:0] stall_count
);
    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu, hold;

    load_use_detect u_lu (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .idex_rd     (idex_rd),
        .idex_memread(idex_memread),
        .lu          (lu)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hold         = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        exmem_bubble = 1'b0;
        mc_done      = 1'b0;
        if (!reset) begin
            // the final busy cycle releases EX and falls through to normal hazard priority
            if (state == MC_BUSY) begin
                hold      = cnt != 4'd0;
                cnt_nxt   = hold ? cnt - 4'd1 : cnt;
                mc_done   = !hold;
                state_nxt = hold ? MC_BUSY : RUN;
            end else if (ex_mc_start) begin
                hold      = 1'b1;
                cnt_nxt   = 4'(MC_LAT - 1);
                state_nxt = MC_BUSY;
            end
            if (hold) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_write && stall_count != '1)
                stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (16-bit and 4-bit stall counter instances).
module tb_hazard_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
    logic idex_memread = 1'b0, ex_branch_taken = 1'b0, ex_mc_start = 1'b0;
    logic pw, iw, xw, xb, ff, eb, md;
    logic pw_s, iw_s, xw_s, xb_s, ff_s, eb_s, md_s;
    logic [15:0] sc;
    logic [3:0]  sc_s;
    logic [6:0]  outs, outs_s;

    typedef struct {string tag; logic [6:0] exp;} exp_t;
    exp_t sb[$];
    int vecs = 0, fails = 0;
    logic [15:0] m16 = '0;
    logic [3:0]  m4 = '0;

    // {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush, exmem_bubble, mc_done}
    localparam logic [6:0] IDLE = 7'b1110000, LU = 7'b0011000, BR = 7'b1111100, MC = 7'b0000010;

    always #5 clk = ~clk;
    assign outs   = {pw, iw, xw, xb, ff, eb, md};
    assign outs_s = {pw_s, iw_s, xw_s, xb_s, ff_s, eb_s, md_s};

    hazard_ctrl #(.MC_LAT(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .pc_write(pw), .ifid_write(iw), .idex_write(xw), .idex_bubble(xb), .ifid_flush(ff),
        .exmem_bubble(eb), .mc_done(md), .stall_count(sc));

    hazard_ctrl #(.MC_LAT(4), .STALL_CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .pc_write(pw_s), .ifid_write(iw_s), .idex_write(xw_s), .idex_bubble(xb_s), .ifid_flush(ff_s),
        .exmem_bubble(eb_s), .mc_done(md_s), .stall_count(sc_s));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one cycle at posedge+1, compare outputs at the falling edge, stall counts after the edge
    task automatic apply(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic mr, input logic br, input logic mc,
                         input logic [6:0] exp);
        exp_t e;
        id_rs1 = rs1; id_rs2 = rs2; idex_rd = rd;
        idex_memread = mr; ex_branch_taken = br; ex_mc_start = mc;
        sb.push_back('{tag, exp});
        #4;
        e = sb.pop_front();
        chk({e.tag, "_outs"}, {9'd0, outs}, {9'd0, e.exp});
        chk({e.tag, "_outs_s"}, {9'd0, outs_s}, {9'd0, e.exp});
        if (!e.exp[6]) begin
            if (m16 != 16'hffff) m16 = m16 + 16'd1;
            if (m4 != 4'hf) m4 = m4 + 4'd1;
        end
        @(posedge clk);
        #1;
        chk({e.tag, "_stall"}, sc, m16);
        chk({e.tag, "_stall_s"}, {12'd0, sc_s}, {12'd0, m4});
    endtask

    initial begin
        idex_memread = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; ex_mc_start = 1'b1; ex_branch_taken = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outs", {9'd0, outs}, {9'd0, IDLE});
        chk("rst_stall", sc, 16'd0);
        reset = 1'b0;
        apply("idle",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
        apply("lu_rs2",   5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, LU);
        apply("lu_miss",  5'd1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, IDLE);
        apply("x0_dest",  5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, IDLE);
        apply("no_load",  5'd3, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);
        apply("br_vs_lu", 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, BR);
        apply("lu_rs1",   5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, LU);
        apply("mc0",      5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MC);
        for (int i = 1; i < 4; i++)
            apply($sformatf("mc%0d", i), 5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, MC);
        apply("mc_done",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE | 7'b1);
        apply("idle2",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
        apply("mcb0",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MC);
        for (int i = 1; i < 4; i++)
            apply($sformatf("mcb%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MC);
        apply("done_lu",  5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, LU | 7'b1);
        apply("after_lu", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
        apply("mcc0",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MC);
        for (int i = 1; i < 4; i++)
            apply($sformatf("mcc%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MC);
        apply("done_br",  5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, BR | 7'b1);
        apply("after_br", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
        apply("abort0",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MC);
        apply("abort1",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MC);
        ex_mc_start = 1'b1;
        reset = 1'b1;
        #2;
        chk("abort_outs", {9'd0, outs}, {9'd0, IDLE});
        chk("abort_stall", sc, 16'd0);
        chk("abort_stall_s", {12'd0, sc_s}, 16'd0);
        m16 = '0;
        m4 = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            apply($sformatf("post_rst%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
        for (int i = 0; i < 20; i++)
            apply($sformatf("sat%0d", i), 5'd2, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, LU);
        chk("sat_final_s", {12'd0, sc_s}, 16'd15);
        chk("sat_final", sc, 16'd20);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MC_LAT, 4, number of cycles the EX stage is held for a multi-cycle ALU op; legal range 2..15.
REQ-002 Parameter STALL_CNT_W, 16, width of the stall statistics counter.
REQ-003 Clocking is fixed: one clock, `clk`, with a single reset, `reset`, that is asynchronous and active-high.
REQ-004 Ports (name direction width meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- idex_rd  in  5  destination register of the instruction in EX.
- idex_memread  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch in EX resolved taken (branch & zero).
- ex_mc_start  in  1  instruction in EX is a multi-cycle ALU op.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- idex_write  out  1  ID/EX register write enable.
- idex_bubble  out  1  zero the control bits entering ID/EX.
- ifid_flush  out  1  clear IF/ID to NOP.
- exmem_bubble  out  1  zero the control bits entering EX/MEM.
- mc_done  out  1  one-cycle pulse when the multi-cycle result is valid.
- stall_count  out  STALL_CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-005 State machine states are RUN and MC_BUSY; there is a 4-bit down-counter cnt.
REQ-006 Outputs are combinational from the registered state, cnt and the inputs; state, cnt and stall_count are the only flops.
REQ-007 Idle output values are pc_write=1, ifid_write=1, idex_write=1, and all other 1-bit outputs 0.
REQ-008 Load-use hazard is defined as lu = idex_memread & (idex_rd!=0) & (idex_rd==id_rs1 | idex_rd==id_rs2).
REQ-009 Priority in RUN is ex_mc_start, then ex_branch_taken, then lu, then idle.
REQ-010 RUN with ex_mc_start:
- pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
- cnt is loaded with MC_LAT-1; the next state is MC_BUSY.
REQ-011 RUN with ex_branch_taken (no ex_mc_start):
- ifid_flush=1, idex_bubble=1, pc_write=1.
- The state remains RUN.
REQ-012 RUN with lu only: pc_write=0, ifid_write=0, idex_bubble=1, and the state remains RUN; this is exactly a one-cycle stall per occurrence.
REQ-013 MC_BUSY with cnt!=0:
- Outputs are as in REQ-010.
- cnt decrements.
- ex_mc_start, ex_branch_taken and lu are ignored.
REQ-014 MC_BUSY with cnt==0:
- mc_done=1, and the next state is RUN.
- Hazard outputs follow the REQ-009 priority, except that ex_mc_start is ignored.
REQ-015 Hold timing: the hold lasts exactly MC_LAT cycles (the start cycle plus MC_LAT-1 busy cycles), and mc_done follows in cycle MC_LAT.
REQ-016 stall_count increments on every clock edge where pc_write=0 and saturates at all-ones with no wrap.

Reset
REQ-017 While reset is high:
- state=RUN, cnt=0 and stall_count=0, applied asynchronously.
- Outputs hold their idle values (REQ-007) regardless of the inputs.
REQ-018 Reset asserted mid-MC_BUSY aborts the sequence with no mc_done pulse; the first cycle after deassertion is evaluated in RUN.

Structure
REQ-019 Shared package hazard_pkg holds the state enum (RUN, MC_BUSY) and the MC_LAT default constant.
REQ-020 A single combinational sub-module, load_use_detect, computes lu; the FSM, counter and statistics logic stay in hazard_ctrl.

Verification
REQ-021 Load-use: idex_memread=1, idex_rd=5, id_rs2=5 in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle, and stall_count goes 0->1.
REQ-022 x0 destination: idex_memread=1, idex_rd=0, id_rs1=0 -> idle outputs and no stall.
REQ-023 Branch versus load-use: ex_branch_taken=1 and lu=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, and stall_count is unchanged.
REQ-024 Multi-cycle op with MC_LAT=4 and ex_mc_start at cycle 0:
- pc_write=0 and exmem_bubble=1 in cycles 0-3.
- mc_done=1 in cycle 4 only.
- stall_count=4 afterwards.
REQ-025 Reset abort: reset pulsed in cycle 2 of an MC_LAT=4 sequence -> outputs idle immediately, no mc_done, and stall_count=0.
REQ-026 Saturation: with STALL_CNT_W=4, 20 consecutive load-use cycles -> stall_count holds at 15.
